// File: rtl/muldiv_unit.sv
// muldiv_unit: EX-stage HI/LO multiply/divide unit.
//   Owns the architectural HI/LO registers. Multiplies complete after MUL_LAT
//   cycles; divides use a 32-iteration restoring divider plus one sign-fix
//   cycle (33 busy cycles). MTHI/MTLO write HI/LO on the accept edge.
// Ports:
//   clk     in   clock, all state changes on posedge
//   rst     in   synchronous active-high reset
//   start   in   request, sampled only while idle
//   op      in   [2:0] 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                100 MTHI, 101 MTLO, 110/111 no-op
//   a       in   [31:0] rs operand
//   b       in   [31:0] rt operand
//   cancel  in   abort an in-flight op / suppress a start
//   busy    out  registered, high while a MUL/DIV op is in flight
//   hi      out  [31:0] HI register
//   lo      out  [31:0] LO register
module muldiv_unit #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);

    state_e      state_q;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  cnt_q;

    logic [31:0] a_q;          // raw a (MUL operand, or HI value on divide by zero)
    logic [31:0] b_q;          // MUL operand, or divisor magnitude
    logic        sgn_q;        // signed multiply
    logic [31:0] quot_q;       // dividend magnitude shifting out, quotient shifting in
    logic [31:0] rem_q;        // partial remainder
    logic        qneg_q;       // negate quotient at fix-up
    logic        rneg_q;       // negate remainder at fix-up (dividend sign)
    logic        dzero_q;      // divisor was zero

    // Operand magnitudes for the signed divide path
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        div_signed = (op == OP_DIV);
        a_mag      = (div_signed && a[31]) ? (32'd0 - a) : a;
        b_mag      = (div_signed && b[31]) ? (32'd0 - b) : b;
    end

    // Multiplier: sign/zero extend to 64 bits; the low 64 bits of the
    // modular product are the exact signed or unsigned result.
    logic [63:0] mul_x;
    logic [63:0] mul_y;
    logic [63:0] prod_d;

    always_comb begin
        mul_x  = {{32{sgn_q & a_q[31]}}, a_q};
        mul_y  = {{32{sgn_q & b_q[31]}}, b_q};
        prod_d = mul_x * mul_y;
    end

    // One restoring-divide step. The shifted remainder is below twice the
    // divisor, so bit 32 of the trial difference is a reliable borrow flag.
    logic [32:0] trial_d;
    logic [31:0] rem_d;
    logic [31:0] quot_d;

    always_comb begin
        trial_d = {rem_q, quot_q[31]} - {1'b0, b_q};
        if (!trial_d[32]) begin
            rem_d  = trial_d[31:0];
            quot_d = {quot_q[30:0], 1'b1};
        end else begin
            rem_d  = {rem_q[30:0], quot_q[31]};
            quot_d = {quot_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else if (cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                a_q     <= a;
                                b_q     <= b;
                                sgn_q   <= (op == OP_MULT);
                                cnt_q   <= MUL_CNT_INIT;
                                busy_q  <= 1'b1;
                                state_q <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q     <= a;
                                b_q     <= b_mag;
                                quot_q  <= a_mag;
                                rem_q   <= '0;
                                qneg_q  <= div_signed & (a[31] ^ b[31]);
                                rneg_q  <= div_signed & a[31];
                                dzero_q <= (b == 32'd0);
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= S_DIV;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q != 5'd0) begin
                        cnt_q <= cnt_q - 5'd1;
                    end else begin
                        hi_q    <= prod_d[63:32];
                        lo_q    <= prod_d[31:0];
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_DIV: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    if (cnt_q == 5'd31) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                S_FIX: begin
                    if (dzero_q) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rneg_q ? (32'd0 - rem_q)  : rem_q;
                        lo_q <= qneg_q ? (32'd0 - quot_q) : quot_q;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit (MUL_LAT = 3).
module tb_muldiv_unit;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.MUL_LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one op, scramble operands after the accept edge, and count busy cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cycles);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    int cyc;

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0; cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b0;

        // MULT -2 * 3
        run_op(3'b000, 32'hFFFF_FFFE, 32'd3, cyc);
        check("mult_cyc", 32'(cyc), 32'(LAT));
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU max * max
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // MULT most-negative * 1
        run_op(3'b000, 32'h8000_0000, 32'd1, cyc);
        check("multmin_hi", hi, 32'hFFFF_FFFF);
        check("multmin_lo", lo, 32'h8000_0000);

        // DIV -7 / 2
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_cyc", 32'(cyc), 32'd33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2
        run_op(3'b010, 32'd7, 32'hFFFF_FFFE, cyc);
        check("div2_lo", lo, 32'hFFFF_FFFD);
        check("div2_hi", hi, 32'd1);

        // DIVU 0xFFFFFFFF / 16
        run_op(3'b011, 32'hFFFF_FFFF, 32'd16, cyc);
        check("divu_lo", lo, 32'h0FFF_FFFF);
        check("divu_hi", hi, 32'h0000_000F);

        // DIVU 100 / 0
        run_op(3'b011, 32'd100, 32'd0, cyc);
        check("divu0_cyc", 32'(cyc), 32'd33);
        check("divu0_hi", hi, 32'd100);
        check("divu0_lo", lo, 32'hFFFF_FFFF);

        // DIV -5 / 0
        run_op(3'b010, 32'hFFFF_FFFB, 32'd0, cyc);
        check("div0_hi", hi, 32'hFFFF_FFFB);
        check("div0_lo", lo, 32'hFFFF_FFFF);

        // DIV overflow
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        // MTHI / MTLO
        run_op(3'b100, 32'h0000_1234, 32'd0, cyc);
        check("mthi_cyc", 32'(cyc), 32'd0);
        check("mthi_hi", hi, 32'h0000_1234);
        run_op(3'b101, 32'h0000_5678, 32'd0, cyc);
        check("mtlo_lo", lo, 32'h0000_5678);
        check("mtlo_hi", hi, 32'h0000_1234);

        // No-op encoding
        run_op(3'b110, 32'hAAAA_AAAA, 32'hBBBB_BBBB, cyc);
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", hi, 32'h0000_1234);
        check("nop_lo", lo, 32'h0000_5678);

        // cancel in IDLE suppresses MTLO
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_idle_lo", lo, 32'h0000_5678);
        check("cancel_idle_busy", {31'd0, busy}, 32'd0);

        // DIVU in flight: ignored second start, then cancel
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;                 // E0
        start = 1'b0;
        check("cx_busy_e0", {31'd0, busy}, 32'd1);
        repeat (5) @(posedge clk);
        #1;                                 // E5
        start = 1'b1; op = 3'b100; a = 32'h0000_DEAD;
        @(posedge clk); #1;                 // E6
        start = 1'b0;
        check("cx_ignored_hi", hi, 32'h0000_1234);
        repeat (4) @(posedge clk);
        #1;                                 // E10
        check("cx_busy_e10", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(posedge clk); #1;                 // E11
        cancel = 1'b0;
        check("cx_busy_e11", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("cx_hi", hi, 32'h0000_1234);
        check("cx_lo", lo, 32'h0000_5678);

        // Unit still usable after cancel
        run_op(3'b001, 32'd3, 32'd4, cyc);
        check("post_cx_hi", hi, 32'd0);
        check("post_cx_lo", lo, 32'd12);

        // rst mid-DIV
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd50; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_hi", hi, 32'd0);
        check("rstmid_lo", lo, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("rstmid_late_lo", lo, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
